// File: rtl/mdu_iter.sv
// Iterative MUL/DIV/REM unit: shift-add multiply, restoring divide, full or half ("word") width.
// Latency N+1 cycles from accept to out_valid (N = WIDTH or WIDTH/2); result held until out_ready.
module mdu_iter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             word,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c
);
    localparam int H = WIDTH / 2;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic             r_word, r_is_div, r_neg_q, r_neg_r, r_dz, r_out_valid;
    logic [WIDTH-1:0] r_x, r_y, r_z, r_a_orig, r_c;

    logic             w_signed, w_is_div, w_sa, w_sb, w_dz;
    logic [WIDTH-1:0] w_mask, w_a_n, w_b_n, w_a_neg, w_b_neg, w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_shift, w_diff;
    logic [WIDTH-1:0] w_x_nx, w_y_nx, w_z_nx, w_q, w_r, w_raw, w_res;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign c         = r_c;

    // Operand pre-processing: narrow to N bits, then take magnitudes for signed divides.
    assign w_signed = (op == 3'd1) || (op == 3'd3);
    assign w_is_div = (op >= 3'd1) && (op <= 3'd4);
    assign w_mask   = word ? {{H{1'b0}}, {H{1'b1}}} : {WIDTH{1'b1}};
    assign w_a_n    = a & w_mask;
    assign w_b_n    = b & w_mask;
    assign w_sa     = w_signed & (word ? a[H-1] : a[WIDTH-1]);
    assign w_sb     = w_signed & (word ? b[H-1] : b[WIDTH-1]);
    assign w_a_neg  = -w_a_n;
    assign w_b_neg  = -w_b_n;
    assign w_a_mag  = (w_sa ? w_a_neg : w_a_n) & w_mask;
    assign w_b_mag  = (w_sb ? w_b_neg : w_b_n) & w_mask;
    assign w_dz     = (w_b_n == '0);

    // Dividend is left-aligned in r_y so the next bit always comes from the MSB.
    assign w_shift = {r_z, r_y[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_x};

    always_comb begin
        w_x_nx = r_x;
        w_y_nx = r_y;
        w_z_nx = r_z;
        if (r_is_div) begin
            w_z_nx = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            w_y_nx = {r_y[WIDTH-2:0], ~w_diff[WIDTH]};
        end else begin
            w_z_nx = r_z + (r_y[0] ? r_x : '0);
            w_x_nx = r_x << 1;
            w_y_nx = r_y >> 1;
        end
    end

    assign w_q = r_neg_q ? -w_y_nx : w_y_nx;
    assign w_r = r_neg_r ? -w_z_nx : w_z_nx;

    always_comb begin
        w_raw = '0;
        case (r_op)
            3'd0:       w_raw = w_z_nx;
            3'd1, 3'd2: w_raw = r_dz ? {WIDTH{1'b1}} : w_q;
            3'd3, 3'd4: w_raw = r_dz ? r_a_orig : w_r;
            default:    w_raw = '0;
        endcase
    end

    assign w_res = r_word ? {{H{w_raw[H-1]}}, w_raw[H-1:0]} : w_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_cnt       <= '0;
            r_op        <= '0;
            r_word      <= 1'b0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz        <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_a_orig    <= '0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_op     <= op;
                    r_word   <= word;
                    r_is_div <= w_is_div;
                    r_neg_q  <= w_sa ^ w_sb;
                    r_neg_r  <= w_sa;
                    r_dz     <= w_dz;
                    r_a_orig <= w_a_n;
                    r_z      <= '0;
                    if (w_is_div) begin
                        r_x <= w_b_mag;
                        r_y <= word ? (w_a_mag << H) : w_a_mag;
                    end else begin
                        r_x <= w_a_n;
                        r_y <= w_b_n;
                    end
                    r_cnt   <= word ? CNT_W'(H) : CNT_W'(WIDTH);
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    r_x   <= w_x_nx;
                    r_y   <= w_y_nx;
                    r_z   <= w_z_nx;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_c         <= w_res;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed spec cases plus randomized ops against an arithmetic reference model.
module tb_mdu_iter;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready, word, out_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b, c;
    int           checks = 0;
    int           passes = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .word(word), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c)
    );

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] model(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        int              s32x, s32y;
        int unsigned     u32x, u32y;
        logic [31:0]     r32;
        logic [63:0]     r;
        sx = x; sy = y; ux = x; uy = y;
        s32x = x[31:0]; s32y = y[31:0]; u32x = x[31:0]; u32y = y[31:0];
        r = '0; r32 = '0;
        if (w) begin
            case (o)
                3'd0: r32 = u32x * u32y;
                3'd1: if (u32y == 0) r32 = '1;
                      else if (u32x == 32'h8000_0000 && u32y == 32'hFFFF_FFFF) r32 = u32x;
                      else r32 = s32x / s32y;
                3'd2: if (u32y == 0) r32 = '1; else r32 = u32x / u32y;
                3'd3: if (u32y == 0) r32 = u32x;
                      else if (u32x == 32'h8000_0000 && u32y == 32'hFFFF_FFFF) r32 = '0;
                      else r32 = s32x % s32y;
                3'd4: if (u32y == 0) r32 = u32x; else r32 = u32x % u32y;
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (o)
                3'd0: r = ux * uy;
                3'd1: if (uy == 0) r = '1;
                      else if (ux == 64'h8000_0000_0000_0000 && uy == 64'hFFFF_FFFF_FFFF_FFFF) r = ux;
                      else r = sx / sy;
                3'd2: if (uy == 0) r = '1; else r = ux / uy;
                3'd3: if (uy == 0) r = ux;
                      else if (ux == 64'h8000_0000_0000_0000 && uy == 64'hFFFF_FFFF_FFFF_FFFF) r = '0;
                      else r = sx % sy;
                3'd4: if (uy == 0) r = ux; else r = ux % uy;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Issues one request with out_ready high; lat counts edges from accept to out_valid (200 = timed out).
    task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y,
                          output logic [63:0] res, output int lat);
        int guard = 0;
        out_ready = 1'b1;
        while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        op = o; word = w; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = rnd64(); b = rnd64(); op = 3'($urandom_range(0, 7)); word = ~w;
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        res = c;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; word = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
        checks++; if (c !== 64'h0) $display("FAIL reset_c: got %h want 0", c); else passes++;
    endtask

    task automatic test_mul_basic;
        logic [63:0] r; int lat;
        run_op(3'd0, 1'b0, 64'd3, 64'd7, r, lat);
        checks++; if (r !== 64'd21) $display("FAIL mul_3x7: got %h want %h", r, 64'd21); else passes++;
        checks++; if (lat !== 64) $display("FAIL mul_latency: got %0d want 64", lat); else passes++;
    endtask

    task automatic test_word_div;
        logic [63:0] r; int lat;
        run_op(3'd1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, r, lat);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL wdiv_m7_2: got %h want fffffffffffffffd", r); else passes++;
        checks++; if (lat !== 32) $display("FAIL wdiv_latency: got %0d want 32", lat); else passes++;
        run_op(3'd3, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, r, lat);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrem_m7_2: got %h want ffffffffffffffff", r); else passes++;
    endtask

    task automatic test_div_zero;
        logic [63:0] r; int lat;
        run_op(3'd2, 1'b0, 64'd100, 64'd0, r, lat);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL divu_by0: got %h want ffffffffffffffff", r); else passes++;
        checks++; if (lat !== 64) $display("FAIL divu_by0_latency: got %0d want 64", lat); else passes++;
        run_op(3'd4, 1'b0, 64'd100, 64'd0, r, lat);
        checks++; if (r !== 64'd100) $display("FAIL remu_by0: got %h want %h", r, 64'd100); else passes++;
    endtask

    task automatic test_overflow;
        logic [63:0] r; int lat;
        run_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
        checks++; if (r !== 64'h8000_0000_0000_0000) $display("FAIL div_ovf: got %h want 8000000000000000", r); else passes++;
        run_op(3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
        checks++; if (r !== 64'h0) $display("FAIL rem_ovf: got %h want 0", r); else passes++;
    endtask

    task automatic test_random;
        logic [63:0] r, x, y, e; logic [2:0] o; logic w; int lat;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7)); w = 1'($urandom_range(0, 1));
            x = rnd64(); y = rnd64();
            case ($urandom_range(0, 5))
                0: y = w ? {$urandom(), 32'h0} : 64'h0;
                1: begin y = '1; x = w ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000; end
                2: y = 64'($urandom_range(1, 20)) | (w ? {$urandom(), 32'h0} : 64'h0);
                default: ;
            endcase
            e = model(o, w, x, y);
            run_op(o, w, x, y, r, lat);
            checks++; if (r !== e) $display("FAIL rand_result op=%0d word=%0d a=%h b=%h: got %h want %h", o, w, x, y, r, e); else passes++;
            checks++; if (lat !== (w ? 32 : 64)) $display("FAIL rand_latency op=%0d word=%0d: got %0d want %0d", o, w, lat, w ? 32 : 64); else passes++;
        end
    endtask

    task automatic test_hold;
        logic [63:0] x, y, e, r; int guard = 0; int lat;
        x = rnd64(); y = rnd64(); e = model(3'd0, 1'b0, x, y);
        out_ready = 1'b0; op = 3'd0; word = 1'b0; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; a = rnd64(); b = rnd64();
        while (!out_valid && guard < 200) begin @(posedge clk); #1; guard++; end
        checks++; if (c !== e) $display("FAIL hold_result: got %h want %h", c, e); else passes++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, c} !== {1'b1, 1'b0, e})
                $display("FAIL hold_stable cyc%0d: got v=%b rdy=%b c=%h want v=1 rdy=0 c=%h", i, out_valid, in_ready, c, e);
            else passes++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL hold_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); else passes++;
        run_op(3'd0, 1'b0, 64'd6, 64'd9, r, lat);
        checks++; if (r !== 64'd54) $display("FAIL hold_next: got %h want %h", r, 64'd54); else passes++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] q[$]; int acc_t[$]; logic [63:0] e;
        out_ready = 1'b1; op = 3'd0; word = 1'b1; in_valid = 1'b1;
        for (int t = 0; t < 140; t++) begin
            if (out_valid) begin
                e = (q.size() > 0) ? q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
                checks++; if (c !== e) $display("FAIL b2b_result t=%0d: got %h want %h", t, c, e); else passes++;
            end
            if (t >= 110) in_valid = 1'b0;
            a = rnd64(); b = rnd64();
            if (in_ready && in_valid) begin q.push_back(model(3'd0, 1'b1, a, b)); acc_t.push_back(t); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (acc_t.size() !== 4) $display("FAIL b2b_accepts: got %0d want 4", acc_t.size()); else passes++;
        for (int i = 1; i < acc_t.size(); i++) begin
            checks++;
            if (acc_t[i] - acc_t[i-1] !== 34) $display("FAIL b2b_interval: got %0d want 34", acc_t[i] - acc_t[i-1]); else passes++;
        end
        checks++; if (q.size() !== 0) $display("FAIL b2b_drain: got %0d pending want 0", q.size()); else passes++;
    endtask

    task automatic test_flush;
        logic [63:0] r; int seen = 0; int lat;
        out_ready = 1'b1;
        op = 3'd0; word = 1'b0; a = 64'd1; b = 64'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL flush_idle_ignore: got rdy=%b want 1", in_ready); else passes++;
        a = rnd64(); b = rnd64(); in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1 flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL flush_busy: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); else passes++;
        repeat (80) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); else passes++;
        run_op(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, r, lat);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFF6) $display("FAIL flush_then_mul: got %h want fffffffffffffff6", r); else passes++;
    endtask

    task automatic test_reset_mid;
        logic [63:0] r; int seen = 0; int lat;
        out_ready = 1'b1;
        a = rnd64(); b = rnd64(); op = 3'd0; word = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        checks++;
        if ({in_ready, out_valid, c} !== {1'b1, 1'b0, 64'h0})
            $display("FAIL reset_mid: got rdy=%b v=%b c=%h want rdy=1 v=0 c=0", in_ready, out_valid, c);
        else passes++;
        repeat (80) begin @(posedge clk); #1; if (out_valid) seen++; end
        checks++; if (seen !== 0) $display("FAIL reset_mid_no_result: got %0d valid cycles want 0", seen); else passes++;
        run_op(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, r, lat);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFF6) $display("FAIL reset_then_mul: got %h want fffffffffffffff6", r); else passes++;
    endtask

    initial begin
        test_reset;
        test_mul_basic;
        test_word_div;
        test_div_zero;
        test_overflow;
        test_random;
        test_hold;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d so far", passes, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised, multi-cycle multiply/divide unit for the execute stage; it sits beside the single-cycle ALU.
- Takes two WIDTH-bit operands and computes MUL, DIV, DIVU, REM or REMU, in full-width or half-width ("word") mode.
- Uses one iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
- Uses a valid/ready handshake on both sides so the pipeline can stall, and accepts a flush from the hazard unit.

Parameters:
- WIDTH, 64, operand/result width; must be even and >= 8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  abort any operation in flight; return to IDLE next cycle.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- op  in  3  0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU; 5-7 reserved.
- word  in  1  half-width mode: use low WIDTH/2 bits of a and b; sign-extend the WIDTH/2-bit result to WIDTH.
- a  in  WIDTH  operand 1 (multiplicand/dividend).
- b  in  WIDTH  operand 2 (multiplier/divisor).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- c  out  WIDTH  result.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high, on port reset.
- Reset values: state=IDLE, out_valid=0, c=0, counter=0; in_ready=1 in the cycle after reset.
- States:
  - IDLE: in_ready=1. in_valid && !flush latches op, word and the operands. Operands are pre-processed per the rules below, the counter is loaded with N, and the state goes to BUSY.
  - BUSY: one iteration per cycle; counter decrements. When counter reaches 1 and iterates, the result is computed, c is registered and the state goes to DONE.
  - DONE: out_valid=1 and c is held stable. out_ready goes to IDLE next cycle; otherwise the state stays DONE.
- Iteration count: N = WIDTH in full mode, WIDTH/2 in word mode.
- Latency: request accepted at edge k gives out_valid=1 in the cycle after edge k+N. c is stable until the out handshake.
- Back-to-back: a new request is accepted only in IDLE. The minimum issue interval is N+2 cycles.
- MUL: low N bits of a*b (signedness is irrelevant for the low half). Word mode sign-extends bit N-1.
- Signed DIV/REM:
  - Divide the magnitudes.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - In word mode, signs are bit N-1 of the low halves.
- Divide by zero (divisor low N bits == 0):
  - quotient = all ones (-1), sign-extended in word mode.
  - remainder = dividend (low N bits, sign-extended in word mode).
  - Same latency as a normal divide.
- Signed overflow (dividend = most-negative N-bit value, divisor = -1): quotient = dividend, remainder = 0.
- Reserved op: completes with the normal latency, c = 0.
- Flush has priority over everything except reset.
  - In any state, the next state is IDLE and out_valid=0; the result is discarded.
  - in_valid in the flush cycle is ignored.
- Reset mid-operation: behaves as flush; c is also cleared to 0.
- Input stability: a, b, op and word are sampled only at the accept edge and may change afterwards.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Reset, then full-mode MUL a=3, b=7 -> out_valid exactly 65 cycles after accept, c=21.
- Word DIV a=0x00000000_FFFFFFF9 (-7), b=2 -> c=0xFFFFFFFF_FFFFFFFD (-3); word REM -> c=0xFFFFFFFF_FFFFFFFF (-1); out_valid after 33 cycles.
- Full DIVU a=100, b=0 -> c=0xFFFFFFFF_FFFFFFFF; REMU a=100, b=0 -> c=100.
- Full DIV a=0x8000000000000000, b=-1 -> c=0x8000000000000000; REM -> c=0.
- Result held with out_ready=0 for 10 cycles -> c and out_valid stable, in_ready=0; then out_ready=1 -> in_ready=1 next cycle and a new request is accepted.
- Flush at BUSY cycle 20 -> out_valid never rises, in_ready=1 next cycle; a following MUL a=-2, b=5 -> c=0xFFFFFFFF_FFFFFFF6. Repeat with reset instead of flush -> c=0.
